// File: rtl/echo_pkg.sv
// Shared echo message definitions for the request decoder and indication encoder.
// Provides message width, tags, field offsets, the message struct and the rule count.
package echo_pkg;

  localparam int ECHO_MSG_W = 96;

  localparam logic [31:0] TAG_SAY   = 32'd1;
  localparam logic [31:0] TAG_HEARD = 32'd1;

  localparam int TAG_LSB  = 0;
  localparam int METH_LSB = 32;
  localparam int V_LSB    = 64;
  localparam int FIELD_W  = 32;

  // Send rule only; no extra scheduled rules in this block.
  localparam int RULE_COUNT = 0;

  // Packed MSB-first: v lands in [95:64], meth in [63:32], tag in [31:0].
  typedef struct packed {
    logic [FIELD_W-1:0] v;
    logic [FIELD_W-1:0] meth;
    logic [FIELD_W-1:0] tag;
  } echo_msg_t;

  function automatic echo_msg_t encode_msg(
    input logic [FIELD_W-1:0] tag,
    input logic [FIELD_W-1:0] meth,
    input logic [FIELD_W-1:0] v
  );
    echo_msg_t m;
    m.tag  = tag;
    m.meth = meth;
    m.v    = v;
    return m;
  endfunction

endpackage

// File: rtl/l_class_oc_echoindicationoutput_fifo.sv
// Generic DEPTH x W synchronous FIFO with full/empty flags and sync reset.
// Ports: clk, rst, wr_en/wr_data, rd_en, rd_data (head entry), full, empty.
module l_class_OC_EchoIndicationOutput_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Head always comes from storage, so a write never bypasses to rd_data.
  assign rd_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[tail] <= wr_data;
        tail      <= tail + AW'(1);
      end
      if (do_rd) begin
        head <= head + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l_class_oc_echoindicationoutput.sv
// Encodes indication.heard(meth, v) calls into 96-bit pipe messages via a FIFO.
// Ports: CLK/RST, heard call (ENA/meth/v/RDY), pipe_enq (ENA/v/RDY), rule vectors, msg_count.
module l_class_oc_echoindicationoutput
  import echo_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] TAG_HEARD = echo_pkg::TAG_HEARD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  indication_heard__ENA,
  input  logic [31:0]           indication_heard_meth,
  input  logic [31:0]           indication_heard_v,
  output logic                  indication_heard__RDY,
  output logic                  pipe_enq__ENA,
  output logic [ECHO_MSG_W-1:0] pipe_enq_v,
  input  logic                  pipe_enq__RDY,
  input  logic [RULE_COUNT:0]   rule_enable,
  output logic [RULE_COUNT:0]   rule_ready,
  output logic [31:0]           msg_count
);

  echo_msg_t enc;
  logic      full;
  logic      empty;
  logic      accept;
  logic      send_guard;
  logic      send;

  assign enc = encode_msg(TAG_HEARD,
                          indication_heard_meth,
                          indication_heard_v);

  assign indication_heard__RDY = ~full;
  assign accept = indication_heard__ENA & indication_heard__RDY;

  assign send_guard    = ~empty & pipe_enq__RDY;
  assign send          = rule_enable[0] & send_guard;
  assign pipe_enq__ENA = send;

  always_comb begin
    rule_ready    = '0;
    rule_ready[0] = send_guard;
  end

  l_class_OC_EchoIndicationOutput_fifo #(
    .DEPTH (DEPTH),
    .W     (ECHO_MSG_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (accept),
    .wr_data (enc),
    .rd_en   (send),
    .rd_data (pipe_enq_v),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      msg_count <= '0;
    end else if (send) begin
      msg_count <= msg_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_l_class_oc_echoindicationoutput.sv
// Randomized and directed bench for the echo indication encoder.
// Reference model: a queue of pending messages plus a sent counter.
module tb_l_class_oc_echoindicationoutput;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        indication_heard__ENA;
  logic [31:0] indication_heard_meth;
  logic [31:0] indication_heard_v;
  logic        indication_heard__RDY;
  logic        pipe_enq__ENA;
  logic [95:0] pipe_enq_v;
  logic        pipe_enq__RDY;
  logic [0:0]  rule_enable;
  logic [0:0]  rule_ready;
  logic [31:0] msg_count;

  int errs   = 0;
  int checks = 0;

  logic [95:0] q [$];
  logic [31:0] mc;
  bit          known = 0;

  always #5 CLK = ~CLK;

  l_class_oc_echoindicationoutput #(
    .DEPTH     (DEPTH),
    .TAG_HEARD (32'd1)
  ) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .indication_heard__ENA (indication_heard__ENA),
    .indication_heard_meth (indication_heard_meth),
    .indication_heard_v    (indication_heard_v),
    .indication_heard__RDY (indication_heard__RDY),
    .pipe_enq__ENA         (pipe_enq__ENA),
    .pipe_enq_v            (pipe_enq_v),
    .pipe_enq__RDY         (pipe_enq__RDY),
    .rule_enable           (rule_enable),
    .rule_ready            (rule_ready),
    .msg_count             (msg_count)
  );

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, clock, update model.
  task automatic step(input bit rst, input bit ena,
                      input logic [31:0] m, input logic [31:0] vv,
                      input bit prdy, input bit ren);
    bit exp_rdy, exp_rr, exp_en;
    RST                   = rst;
    indication_heard__ENA = ena;
    indication_heard_meth = m;
    indication_heard_v    = vv;
    pipe_enq__RDY         = prdy;
    rule_enable           = ren;
    #1;
    exp_rdy = (q.size() != DEPTH);
    exp_rr  = (q.size() != 0) && prdy;
    exp_en  = exp_rr && ren;
    if (known) begin
      chk("rdy", 96'(indication_heard__RDY), 96'(exp_rdy));
      chk("rule_ready", 96'(rule_ready), 96'(exp_rr));
      chk("enq_ena", 96'(pipe_enq__ENA), 96'(exp_en));
      chk("msg_count", 96'(msg_count), 96'(mc));
      if (q.size() != 0) chk("enq_v", pipe_enq_v, q[0]);
    end
    @(posedge CLK);
    if (rst) begin
      q.delete();
      mc    = 0;
      known = 1;
    end else begin
      if (exp_en) begin
        void'(q.pop_front());
        mc++;
      end
      if (ena && exp_rdy) q.push_back({vv, m, 32'd1});
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    logic [95:0] held;
    @(negedge CLK);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_v", pipe_enq_v, 96'd0);
    chk("rst_cnt", 96'(msg_count), 96'd0);
    chk("rst_rdy", 96'(indication_heard__RDY), 96'd1);

    // Single message with one-cycle latency.
    step(0, 1, 32'd5, 32'h1234, 1, 1);
    chk("single_v", pipe_enq_v, {32'h1234, 32'd5, 32'd1});
    chk("single_en", 96'(pipe_enq__ENA), 96'd1);
    idle(1);
    chk("single_cnt", 96'(msg_count), 96'd1);

    // Back-pressure fill: third call must be dropped.
    for (int i = 1; i <= 3; i++) step(0, 1, 32'd7, 32'(i), 0, 1);
    chk("bp_len", 96'(q.size()), 96'd2);
    idle(4);
    chk("bp_cnt", 96'(msg_count), 96'd3);

    // Rule gating holds the head.
    step(0, 1, 32'd9, 32'hABCD, 1, 0);
    held = pipe_enq_v;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("gate_hold", pipe_enq_v, held);
    idle(2);
    chk("gate_cnt", 96'(msg_count), 96'd4);

    // Full, then send with a call in the same cycle.
    step(0, 1, 32'd1, 32'd10, 0, 1);
    step(0, 1, 32'd1, 32'd11, 0, 1);
    step(0, 1, 32'd1, 32'd12, 1, 1);
    chk("drain_rdy", 96'(indication_heard__RDY), 96'd1);
    idle(3);

    // Streaming 100 back-to-back.
    for (int i = 0; i < 100; i++) step(0, 1, 32'd2, 32'(i), 1, 1);
    idle(2);
    chk("stream_cnt", 96'(msg_count), 96'd106);

    // Reset with queued entries.
    step(0, 1, 32'd3, 32'd55, 0, 1);
    step(0, 1, 32'd3, 32'd56, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("mrst_v", pipe_enq_v, 96'd0);
    chk("mrst_en", 96'(pipe_enq__ENA), 96'd0);
    chk("mrst_cnt", 96'(msg_count), 96'd0);
    chk("mrst_rdy", 96'(indication_heard__RDY), 96'd1);
    idle(3);

    // Random traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/l_class_oc_echoindicationoutput.md
# l_class_OC_EchoIndicationOutput

Transmit-side counterpart of the echo request decoder: accepts `indication.heard(meth, v)` method calls from the echo core and encodes each into a 96-bit tagged pipe message for the outbound indication pipe. A small FIFO decouples the core from pipe back-pressure. The pipe send is a scheduled rule gated through the `rule_enable`/`rule_ready` vectors.

## Interface
- `DEPTH`, 2, FIFO entries; a power of two, at least 2.
- `TAG_HEARD`, 1, tag value written for `heard` messages.
- `CLK`  in  1  clock.
- `RST`  in  1  synchronous, active-high reset.
- `indication_heard__ENA`  in  1  method call strobe.
- `indication_heard_meth`  in  32  method-id argument.
- `indication_heard_v`  in  32  value argument.
- `indication_heard__RDY`  out  1  method may be called this cycle.
- `pipe_enq__ENA`  out  1  message presented to the pipe this cycle.
- `pipe_enq_v`  out  96  encoded message.
- `pipe_enq__RDY`  in  1  pipe can accept this cycle.
- `rule_enable`  in  `RULE_COUNT+1`  scheduler enable; bit 0 is the send rule.
- `rule_ready`  out  `RULE_COUNT+1`  rule guards; bit 0 is the send-rule guard.
- `msg_count`  out  32  messages sent since reset; wraps.

## Operation
- Message layout:
  - `[31:0]` tag (`TAG_HEARD`)
  - `[63:32]` meth
  - `[95:64]` v
- Accept:
  - `accept = indication_heard__ENA & indication_heard__RDY`.
  - `indication_heard__RDY = (count != DEPTH)`.
  - ENA while RDY is low is ignored: no state change.
  - On accept, the encoded word is written at the tail and the tail pointer advances.
- Send:
  - `rule_ready[0] = (count != 0) & pipe_enq__RDY`.
  - `pipe_enq__ENA = rule_enable[0] & rule_ready[0]`.
  - `pipe_enq_v` is always the head entry, driven from registered storage. It never combinationally passes the call arguments.
  - On `pipe_enq__ENA`, the head pointer advances and `msg_count` increments.
- Occupancy:
  - `count` ranges 0..DEPTH.
  - Accept alone: +1. Send alone: −1. Both together: unchanged.
  - Pointers are `log2(DEPTH)` bits and wrap naturally.
- Boundary cases:
  - Empty: no send is possible. An accept in the same cycle does not bypass to the pipe.
  - Full: RDY is 0, so no accept. A send in that cycle frees one slot, seen as RDY=1 on the next cycle (no same-cycle bypass).
  - `rule_enable[0]` high with the guard low: no effect.
  - Guard high with `rule_enable[0]` low: the entry is held, and the head and `pipe_enq_v` stay stable.
  - Unused `rule_ready` bits are 0; unused `rule_enable` bits are ignored.
- Reset (synchronous, wins over every other event in the same cycle):
  - `count`, head and tail pointers, and `msg_count` go to 0.
  - All storage is zeroed, so `pipe_enq_v` = 0.
  - `pipe_enq__ENA` = 0 and `rule_ready` = 0.
  - `indication_heard__RDY` = 1 from the first cycle after reset.
  - A reset in mid-operation discards all queued messages.

## Timing
- Minimum latency from an accepted call to `pipe_enq__ENA`: 1 cycle (accept at edge N, send possible in cycle N+1).
- Sustained throughput is one message per cycle when the pipe and scheduler are always ready, with DEPTH ≥ 2.
- All outputs are combinational only from registered state plus `pipe_enq__RDY` and `rule_enable`. There is no path from `indication_heard_*` to any pipe output.

## Structure
- Shared package `echo_pkg` holds:
  - `ECHO_MSG_W` = 96.
  - Tag constants `TAG_SAY` = 1 and `TAG_HEARD` = 1.
  - Field offsets and the message struct used by both the request decoder and this block.
  - `RULE_COUNT` for this block (0).
- One sub-module, `l_class_OC_EchoIndicationOutput_fifo`: a generic `DEPTH`×96 synchronous FIFO with count, full and empty flags, and sync reset. The top level does encoding, guards and `msg_count`.

## Test plan
- Single message: reset, then `heard(meth=5, v=0x1234)` with pipe and rule always ready → next cycle `pipe_enq__ENA`=1 and `pipe_enq_v`=`{32'h1234, 32'd5, 32'd1}`; `msg_count`=1.
- Back-pressure fill: hold `pipe_enq__RDY`=0 and call 3× (v=1,2,3) → first two accepted, third ignored with RDY=0. Release the pipe → v=1 then v=2 emitted in order; v=3 never appears.
- Rule gating: entry queued, `pipe_enq__RDY`=1, `rule_enable[0]`=0 for 4 cycles → `rule_ready[0]`=1, `pipe_enq__ENA`=0, `pipe_enq_v` stable. Enable → exactly one send.
- Full and drain together: FIFO full, send fires → RDY=0 that cycle and 1 the next; count goes 2→1.
- Streaming: 100 back-to-back calls with v=0..99, everything ready → 100 consecutive sends in order with one-cycle latency; `msg_count`=100.
- Reset mid-stream: assert `RST` with 2 entries queued → next cycle `pipe_enq__ENA`=0, `pipe_enq_v`=0, `msg_count`=0, RDY=1, and no stale message is ever sent afterwards.
